// File: rtl/gf_pkg.sv
// Shared GF(2^m) constants and arithmetic helpers for the multiplier pipeline
// and its scoreboard reference model.
package gf_pkg;
    localparam int         GF_MAX_M    = 16;
    localparam int         GF_DEF_M    = 8;
    localparam logic [8:0] GF_DEF_POLY = 9'h11D;   // RS(255,239) field

    typedef logic [GF_MAX_M-1:0] gf_elem_t;
    typedef logic [GF_MAX_M:0]   gf_poly_t;

    function automatic gf_elem_t gf_xtime(input gf_elem_t value, input gf_poly_t poly, input int m);
        gf_elem_t mask;
        gf_elem_t r;
        mask = gf_elem_t'((gf_poly_t'(1) << m) - gf_poly_t'(1));
        r    = value << 1;
        if (value[m-1]) r = r ^ poly[GF_MAX_M-1:0];
        return r & mask;
    endfunction

    function automatic gf_elem_t gf_mul(input gf_elem_t a, input gf_elem_t b, input gf_poly_t poly, input int m);
        gf_elem_t p;
        gf_elem_t ai;
        p  = '0;
        ai = b;
        for (int k = 0; k < GF_MAX_M; k++) begin
            if (k < m) begin
                if (a[k]) p = p ^ ai;
                ai = gf_xtime(ai, poly, m);
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/gf_mult_slice.sv
// One pipeline slice of a shift-and-add GF(2^M) multiply: folds W bits of A
// into the running sum and advances the shifted multiple of B by W steps.
module gf_mult_slice
    import gf_pkg::*;
#(
    parameter int         M    = 8,
    parameter logic [M:0] POLY = 9'h11D,
    parameter int         W    = 4
) (
    input  logic [M-1:0] sum_in,
    input  logic [M-1:0] ai_in,
    input  logic [W-1:0] a_bits,
    output logic [M-1:0] sum_out,
    output logic [M-1:0] ai_out
);
    always_comb begin
        logic [M-1:0] acc;
        logic [M-1:0] run;
        acc = sum_in;
        run = ai_in;
        for (int k = 0; k < W; k++) begin
            if (a_bits[k]) acc = acc ^ run;
            run = M'(gf_xtime(gf_elem_t'(run), gf_poly_t'(POLY), M));
        end
        sum_out = acc;
        ai_out  = run;
    end
endmodule

// File: rtl/gf_mult_pipe.sv
// Pipelined GF(2^M) multiplier array: LANES products per beat over PIPE register
// stages, with per-lane reloadable coefficients and valid/ready backpressure.
module gf_mult_pipe
    import gf_pkg::*;
#(
    parameter int           M         = GF_DEF_M,
    parameter logic [M:0]   POLY      = GF_DEF_POLY,
    parameter int           LANES     = 4,
    parameter int           PIPE      = 2,
    parameter logic [M-1:0] COEF_INIT = M'(1),
    localparam int          CLW       = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               const_mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*M-1:0] din_a,
    input  logic [LANES*M-1:0] din_b,
    input  logic               coef_we,
    input  logic [CLW-1:0]     coef_lane,
    input  logic [M-1:0]       coef_din,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*M-1:0] dout
);
    localparam int SL = (M + PIPE - 1) / PIPE;

    logic         stall;
    logic         accept;
    logic [M-1:0] coef_reg [LANES];
    logic [M-1:0] b_sel    [LANES];
    logic [M-1:0] sum_last [LANES];

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall & ~rst;
    assign accept   = in_valid & in_ready;

    // Out-of-range lane indices match no register and are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) coef_reg[i] <= COEF_INIT;
        end else if (coef_we) begin
            for (int i = 0; i < LANES; i++)
                if (coef_lane == CLW'(i)) coef_reg[i] <= coef_din;
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++)
            b_sel[l] = const_mode ? coef_reg[l] : din_b[l*M +: M];
    end

    for (genvar s = 0; s < PIPE; s++) begin : g_stage
        localparam int LO = (s * SL < M) ? s * SL : M;
        localparam int HI = (LO + SL < M) ? LO + SL : M;
        localparam int W  = HI - LO;
        localparam int AQ = M - HI;

        logic vld_i;
        logic vld_q;

        if (s == 0) begin : g_vsrc
            assign vld_i = accept;
        end else begin : g_vsrc
            assign vld_i = g_stage[s-1].vld_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst)         vld_q <= 1'b0;
            else if (!stall) vld_q <= vld_i;
        end

        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic [M-1:0] sum_i;
            logic [M-1:0] sum_d;
            logic [M-1:0] sum_q;

            if (s == 0) begin : g_ssrc
                assign sum_i = '0;
            end else begin : g_ssrc
                assign sum_i = g_stage[s-1].g_lane[l].sum_q;
            end

            // Trailing stages can be empty when PIPE does not divide M evenly.
            if (W > 0) begin : g_work
                logic [M-1:0]    ai_i;
                logic [M-1:0]    ai_d;
                logic [M-LO-1:0] a_i;

                if (s == 0) begin : g_src
                    assign ai_i = b_sel[l];
                    assign a_i  = din_a[l*M +: M];
                end else begin : g_src
                    assign ai_i = g_stage[s-1].g_lane[l].g_work.g_carry.ai_q;
                    assign a_i  = g_stage[s-1].g_lane[l].g_work.g_carry.a_q;
                end

                gf_mult_slice #(.M(M), .POLY(POLY), .W(W)) u_slice (
                    .sum_in (sum_i),
                    .ai_in  (ai_i),
                    .a_bits (a_i[W-1:0]),
                    .sum_out(sum_d),
                    .ai_out (ai_d)
                );

                if (AQ > 0) begin : g_carry
                    logic [M-1:0]  ai_q;
                    logic [AQ-1:0] a_q;
                    always_ff @(posedge clk or posedge rst) begin
                        if (rst) begin
                            ai_q <= '0;
                            a_q  <= '0;
                        end else if (!stall) begin
                            ai_q <= ai_d;
                            a_q  <= a_i[M-LO-1:W];
                        end
                    end
                end
            end else begin : g_idle
                assign sum_d = sum_i;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst)         sum_q <= '0;
                else if (!stall) sum_q <= sum_d;
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_out
        assign sum_last[l] = g_stage[PIPE-1].g_lane[l].sum_q;
    end

    assign out_valid = g_stage[PIPE-1].vld_q;

    always_comb begin
        dout = '0;
        for (int l = 0; l < LANES; l++) dout[l*M +: M] = sum_last[l];
    end
endmodule

// File: tb/tb_gf_mult_pipe.sv
// Scoreboard bench for gf_mult_pipe: default GF(256) 4-lane instance plus a
// GF(16) single-lane, four-stage instance.
module tb_gf_mult_pipe;
    import gf_pkg::*;

    localparam int         M     = 8;
    localparam int         LANES = 4;
    localparam int         PIPE  = 2;
    localparam logic [8:0] POLY  = 9'h11D;
    localparam int         M4    = 4;
    localparam int         PIPE4 = 4;
    localparam logic [4:0] POLY4 = 5'h13;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        const_mode, in_valid, in_ready, coef_we, out_valid, out_ready;
    logic [31:0] din_a, din_b, dout;
    logic [1:0]  coef_lane;
    logic [7:0]  coef_din;

    logic        c4_const_mode, c4_in_valid, c4_in_ready, c4_coef_we, c4_out_valid, c4_out_ready;
    logic [3:0]  c4_din_a, c4_din_b, c4_dout, c4_coef_din;
    logic [0:0]  c4_coef_lane;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sb[$];
    logic [3:0]  sb4[$];
    logic [7:0]  coef_model [LANES];
    logic [3:0]  coef4;

    gf_mult_pipe #(.M(M), .POLY(POLY), .LANES(LANES), .PIPE(PIPE), .COEF_INIT(8'h01)) dut (
        .clk(clk), .rst(rst), .const_mode(const_mode), .in_valid(in_valid), .in_ready(in_ready),
        .din_a(din_a), .din_b(din_b), .coef_we(coef_we), .coef_lane(coef_lane), .coef_din(coef_din),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout)
    );

    gf_mult_pipe #(.M(M4), .POLY(POLY4), .LANES(1), .PIPE(PIPE4), .COEF_INIT(4'h1)) dut4 (
        .clk(clk), .rst(rst), .const_mode(c4_const_mode), .in_valid(c4_in_valid), .in_ready(c4_in_ready),
        .din_a(c4_din_a), .din_b(c4_din_b), .coef_we(c4_coef_we), .coef_lane(c4_coef_lane),
        .coef_din(c4_coef_din), .out_valid(c4_out_valid), .out_ready(c4_out_ready), .dout(c4_dout)
    );

    function automatic logic [31:0] model_beat(input logic cm, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [7:0]  bb;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            bb = cm ? coef_model[l] : b[l*8 +: 8];
            r[l*8 +: 8] = 8'(gf_mul(gf_elem_t'(a[l*8 +: 8]), gf_elem_t'(bb), gf_poly_t'(POLY), M));
        end
        return r;
    endfunction

    function automatic logic [3:0] model4(input logic cm, input logic [3:0] a, input logic [3:0] b);
        return 4'(gf_mul(gf_elem_t'(a), gf_elem_t'(cm ? coef4 : b), gf_poly_t'(POLY4), M4));
    endfunction

    task automatic step(input logic iv, input logic cm, input logic [31:0] a, input logic [31:0] b,
                        input logic ordy, input logic we, input logic [1:0] wl, input logic [7:0] wd,
                        output logic acc, output logic xf);
        @(negedge clk);
        in_valid = iv; const_mode = cm; din_a = a; din_b = b; out_ready = ordy;
        coef_we = we; coef_lane = wl; coef_din = wd;
        #1;
        acc = in_valid && in_ready;
        xf  = out_valid && out_ready;
    endtask

    task automatic step4(input logic iv, input logic cm, input logic [3:0] a, input logic [3:0] b,
                         input logic ordy, input logic we, input logic wl, input logic [3:0] wd,
                         output logic acc, output logic xf);
        @(negedge clk);
        c4_in_valid = iv; c4_const_mode = cm; c4_din_a = a; c4_din_b = b; c4_out_ready = ordy;
        c4_coef_we = we; c4_coef_lane = wl; c4_coef_din = wd;
        #1;
        acc = c4_in_valid && c4_in_ready;
        xf  = c4_out_valid && c4_out_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 0; const_mode = 0; din_a = 0; din_b = 0; out_ready = 1; coef_we = 0; coef_lane = 0; coef_din = 0;
        c4_in_valid = 0; c4_const_mode = 0; c4_din_a = 0; c4_din_b = 0; c4_out_ready = 1;
        c4_coef_we = 0; c4_coef_lane = 0; c4_coef_din = 0;
        for (int l = 0; l < LANES; l++) coef_model[l] = 8'h01;
        coef4 = 4'h1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_checks++; if (dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", dout); end
        n_checks++; if (c4_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid4: got %b expected 0", c4_out_valid); end
        n_checks++; if (c4_dout !== 4'h0) begin n_fail++; $display("FAIL reset_dout4: got %h expected 0", c4_dout); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic acc, xf;
        int   lat;
        lat = 0;
        step(1, 0, {8'h01, 8'h00, 8'h80, 8'h02}, {8'h5A, 8'hFF, 8'h80, 8'h80}, 1, 0, 0, 0, acc, xf);
        n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL basic_accept: got %b expected 1", acc); end
        for (int c = 1; c <= 8; c++) begin
            step(0, 0, 0, 0, 1, 0, 0, 0, acc, xf);
            if (out_valid) begin lat = c; break; end
        end
        n_checks++; if (lat != PIPE) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, PIPE); end
        n_checks++; if (dout !== 32'h5A00131D) begin n_fail++; $display("FAIL basic_dout: got %h expected 5a00131d", dout); end
        step(0, 0, 0, 0, 1, 0, 0, 0, acc, xf);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_single_beat: got %b expected 0", out_valid); end
    endtask

    task automatic test_coef_update();
        logic acc, xf;
        logic [31:0] got, exp;
        logic [7:0]  exp_l2 [2];
        int k;
        exp_l2[0] = 8'h80; exp_l2[1] = 8'h1D;
        k = 0;
        step(1, 1, {8'h11, 8'h80, 8'h22, 8'h33}, 32'hDEADBEEF, 1, 1, 2'd2, 8'h02, acc, xf);
        if (acc) sb.push_back(model_beat(1, {8'h11, 8'h80, 8'h22, 8'h33}, 32'hDEADBEEF));
        coef_model[2] = 8'h02;
        step(1, 1, {8'h44, 8'h80, 8'h55, 8'h66}, 32'h12345678, 1, 0, 0, 0, acc, xf);
        if (acc) sb.push_back(model_beat(1, {8'h44, 8'h80, 8'h55, 8'h66}, 32'h12345678));
        for (int c = 0; c < 12 && sb.size() > 0; c++) begin
            step(0, 0, 0, 0, 1, 0, 0, 0, acc, xf);
            if (xf) begin
                got = dout; exp = sb.pop_front();
                n_checks++; if (got !== exp) begin n_fail++; $display("FAIL coef_beat: got %h expected %h", got, exp); end
                if (k < 2) begin
                    n_checks++;
                    if (got[23:16] !== exp_l2[k]) begin n_fail++; $display("FAIL coef_lane2_beat%0d: got %h expected %h", k, got[23:16], exp_l2[k]); end
                end
                k++;
            end
        end
        n_checks++; if (k != 2 || sb.size() != 0) begin n_fail++; $display("FAIL coef_drain: got %0d beats expected 2", k); end
    endtask

    task automatic test_backpressure();
        logic acc, xf, cm, ordy, stalled_prev;
        logic [31:0] a, b, held, exp;
        int sent, got;
        sent = 0; got = 0; stalled_prev = 0; held = '0;
        a = $urandom; b = $urandom; cm = 1'($urandom_range(0, 1));
        for (int c = 0; c < 80 && (sent < 12 || sb.size() > 0); c++) begin
            ordy = !(c >= 3 && c < 8);
            step(sent < 12, cm, a, b, ordy, 0, 0, 0, acc, xf);
            if (out_valid && !ordy) begin
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
                if (stalled_prev) begin
                    n_checks++; if (dout !== held) begin n_fail++; $display("FAIL bp_hold: got %h expected %h", dout, held); end
                end
                held = dout; stalled_prev = 1;
            end else begin
                stalled_prev = 0;
            end
            if (xf) begin
                got++;
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL bp_extra_beat: got %h expected none", dout); end
                else begin
                    exp = sb.pop_front();
                    if (dout !== exp) begin n_fail++; $display("FAIL bp_order: got %h expected %h", dout, exp); end
                end
            end
            if (acc) begin
                sb.push_back(model_beat(cm, a, b));
                sent++;
                a = $urandom; b = $urandom; cm = 1'($urandom_range(0, 1));
            end
        end
        n_checks++; if (sent != 12 || got != 12 || sb.size() != 0) begin
            n_fail++; $display("FAIL bp_count: got sent=%0d out=%0d expected 12/12", sent, got);
        end
    endtask

    task automatic test_rst_midflight();
        logic acc, xf;
        int k;
        step(1, 0, 32'h01020304, 32'h05060708, 1, 0, 0, 0, acc, xf);
        if (acc) sb.push_back(model_beat(0, 32'h01020304, 32'h05060708));
        step(1, 0, 32'h090A0B0C, 32'h0D0E0F10, 1, 0, 0, 0, acc, xf);
        if (acc) sb.push_back(model_beat(0, 32'h090A0B0C, 32'h0D0E0F10));
        @(posedge clk); #2;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b expected 1", out_valid); end
        rst = 1'b1; in_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        sb.delete();
        for (int l = 0; l < LANES; l++) coef_model[l] = 8'h01;
        coef4 = 4'h1;
        @(negedge clk);
        rst = 1'b0;
        step(1, 1, 32'h01010101, 32'hFFFFFFFF, 1, 0, 0, 0, acc, xf);
        if (acc) sb.push_back(model_beat(1, 32'h01010101, 32'hFFFFFFFF));
        k = 0;
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            step(0, 0, 0, 0, 1, 0, 0, 0, acc, xf);
            if (xf) begin
                void'(sb.pop_front());
                k++;
                n_checks++; if (dout !== 32'h01010101) begin n_fail++; $display("FAIL rst_coef_init: got %h expected 01010101", dout); end
            end
        end
        n_checks++; if (k != 1) begin n_fail++; $display("FAIL rst_beats: got %0d expected 1", k); end
    endtask

    task automatic test_m4();
        logic acc, xf, ordy;
        logic [3:0] exp;
        int lat, idx, got;
        lat = 0;
        step4(1, 0, 4'h8, 4'h2, 1, 0, 0, 0, acc, xf);
        for (int c = 1; c <= 10; c++) begin
            step4(0, 0, 0, 0, 1, 0, 0, 0, acc, xf);
            if (c4_out_valid) begin lat = c; break; end
        end
        n_checks++; if (lat != PIPE4) begin n_fail++; $display("FAIL m4_latency: got %0d expected %0d", lat, PIPE4); end
        n_checks++; if (c4_dout !== 4'h3) begin n_fail++; $display("FAIL m4_first: got %h expected 3", c4_dout); end

        idx = 0; got = 0;
        for (int c = 0; c < 2000 && (idx < 256 || sb4.size() > 0); c++) begin
            ordy = ($urandom_range(0, 3) != 0);
            step4(idx < 256, 0, 4'(idx >> 4), 4'(idx), ordy, 0, 0, 0, acc, xf);
            if (xf) begin
                got++;
                n_checks++;
                if (sb4.size() == 0) begin n_fail++; $display("FAIL m4_extra_beat: got %h expected none", c4_dout); end
                else begin
                    exp = sb4.pop_front();
                    if (c4_dout !== exp) begin n_fail++; $display("FAIL m4_pair: got %h expected %h", c4_dout, exp); end
                end
            end
            if (acc) begin
                sb4.push_back(model4(0, 4'(idx >> 4), 4'(idx)));
                idx++;
            end
        end
        n_checks++; if (got != 256 || sb4.size() != 0) begin n_fail++; $display("FAIL m4_count: got %0d expected 256", got); end

        step4(1, 1, 4'h1, 4'h0, 1, 1, 1'b1, 4'h7, acc, xf);
        if (acc) sb4.push_back(model4(1, 4'h1, 4'h0));
        step4(1, 1, 4'h8, 4'h0, 1, 0, 0, 0, acc, xf);
        if (acc) sb4.push_back(model4(1, 4'h8, 4'h0));
        step4(0, 0, 0, 0, 1, 1, 1'b0, 4'h5, acc, xf);
        coef4 = 4'h5;
        step4(1, 1, 4'h8, 4'h0, 1, 0, 0, 0, acc, xf);
        if (acc) sb4.push_back(model4(1, 4'h8, 4'h0));
        got = 0;
        for (int c = 0; c < 16 && sb4.size() > 0; c++) begin
            step4(0, 0, 0, 0, 1, 0, 0, 0, acc, xf);
            if (xf) begin
                exp = sb4.pop_front();
                got++;
                n_checks++; if (c4_dout !== exp) begin n_fail++; $display("FAIL m4_coef_beat%0d: got %h expected %h", got, c4_dout, exp); end
            end
        end
        n_checks++; if (got != 3) begin n_fail++; $display("FAIL m4_coef_count: got %0d expected 3", got); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_coef_update();
        test_backpressure();
        test_rst_midflight();
        test_m4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
